// File: rtl/e3_pkg.sv
// Shared constants and frame-state encoding for the serial Excess-3 receive path.
package e3_pkg;
    localparam int unsigned   BITS_PER_DIGIT = 4;
    localparam logic [3:0]    E3_OFFSET      = 4'd3;
    localparam logic [3:0]    E3_MIN         = 4'd3;
    localparam logic [3:0]    E3_MAX         = 4'd12;

    typedef enum logic [1:0] {
        S_B0 = 2'd0,
        S_B1 = 2'd1,
        S_B2 = 2'd2,
        S_B3 = 2'd3
    } frame_state_t;
endpackage

// File: rtl/e3_digit_check.sv
// Combinational Excess-3 check: restores the BCD digit and flags codes outside 3..12.
module e3_digit_check
    import e3_pkg::*;
(
    input  logic [3:0] code,
    output logic [3:0] bcd_digit,
    output logic       code_error
);
    // Subtraction wraps mod 16, so invalid codes still map to a nibble.
    assign bcd_digit  = code - E3_OFFSET;
    assign code_error = (code < E3_MIN) || (code > E3_MAX);
endmodule

// File: rtl/excess3_serial_deserializer.sv
// Assembles LSB-first 4-bit Excess-3 frames from the converter's serial stream,
// restores BCD digits, and keeps a digit history, count and sticky error.
module excess3_serial_deserializer
    import e3_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int COUNT_W    = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    z_in,
    input  logic                    bit_en,
    output logic [3:0]              e3_code,
    output logic [3:0]              bcd_digit,
    output logic                    digit_valid,
    output logic                    code_error,
    output logic                    sticky_error,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [COUNT_W-1:0]      digit_count
);
    localparam int DIGITS_W = 4 * NUM_DIGITS;

    frame_state_t state, state_nxt;
    logic [2:0]   low_bits;
    logic [3:0]   code_new;
    logic [3:0]   bcd_new;
    logic         err_new;

    assign code_new = {z_in, low_bits};

    e3_digit_check u_check (
        .code       (code_new),
        .bcd_digit  (bcd_new),
        .code_error (err_new)
    );

    always_comb begin
        state_nxt = state;
        if (bit_en) begin
            case (state)
                S_B0:    state_nxt = S_B1;
                S_B1:    state_nxt = S_B2;
                S_B2:    state_nxt = S_B3;
                default: state_nxt = S_B0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= S_B0;
            low_bits     <= '0;
            e3_code      <= '0;
            bcd_digit    <= '0;
            digit_valid  <= 1'b0;
            code_error   <= 1'b0;
            sticky_error <= 1'b0;
            digits       <= '0;
            digit_count  <= '0;
        end else begin
            state       <= state_nxt;
            digit_valid <= 1'b0;
            code_error  <= 1'b0;
            if (bit_en) begin
                case (state)
                    S_B0: low_bits[0] <= z_in;
                    S_B1: low_bits[1] <= z_in;
                    S_B2: low_bits[2] <= z_in;
                    default: begin
                        // Completing edge: bit 3 comes straight from z_in.
                        e3_code      <= code_new;
                        bcd_digit    <= bcd_new;
                        code_error   <= err_new;
                        digit_valid  <= 1'b1;
                        sticky_error <= sticky_error | err_new;
                        digits       <= {digits[DIGITS_W-BITS_PER_DIGIT-1:0], bcd_new};
                        if (digit_count != {COUNT_W{1'b1}})
                            digit_count <= digit_count + 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_excess3_serial_deserializer.sv
// Randomized and directed checks of the serial Excess-3 deserializer against a frame-level model.
module tb_excess3_serial_deserializer;
    localparam int NUM_DIGITS = 4;
    localparam int COUNT_W    = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        z_in = 1'b0;
    logic        bit_en = 1'b0;
    logic [3:0]  e3_code, bcd_digit;
    logic        digit_valid, code_error, sticky_error;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [COUNT_W-1:0]      digit_count;

    int checks = 0;
    int failures = 0;

    // Frame-level model state
    int bits_q[$];
    int dig_q[$];
    int m_code, m_bcd, m_count;
    bit m_valid, m_err, m_sticky;

    excess3_serial_deserializer #(.NUM_DIGITS(NUM_DIGITS), .COUNT_W(COUNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .z_in         (z_in),
        .bit_en       (bit_en),
        .e3_code      (e3_code),
        .bcd_digit    (bcd_digit),
        .digit_valid  (digit_valid),
        .code_error   (code_error),
        .sticky_error (sticky_error),
        .digits       (digits),
        .digit_count  (digit_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input bit z);
        int code;
        if (!r) begin
            bits_q.delete(); dig_q.delete();
            m_code = 0; m_bcd = 0; m_count = 0;
            m_valid = 0; m_err = 0; m_sticky = 0;
        end else begin
            m_valid = 0; m_err = 0;
            if (e) begin
                bits_q.push_back(z);
                if (bits_q.size() == 4) begin
                    code = bits_q[0] + 2*bits_q[1] + 4*bits_q[2] + 8*bits_q[3];
                    bits_q.delete();
                    m_code  = code;
                    m_bcd   = (code + 16 - 3) % 16;
                    m_err   = (code < 3) || (code > 12);
                    m_valid = 1;
                    m_sticky = m_sticky | m_err;
                    dig_q.push_back(m_bcd);
                    if (dig_q.size() > NUM_DIGITS) void'(dig_q.pop_front());
                    if (m_count < (1 << COUNT_W) - 1) m_count++;
                end
            end
        end
    endtask

    function automatic int model_digits();
        int v = 0;
        foreach (dig_q[i]) v = v * 16 + dig_q[i];
        return v;
    endfunction

    task automatic compare_all();
        chk("e3_code", 32'(e3_code), 32'(m_code));
        chk("bcd_digit", 32'(bcd_digit), 32'(m_bcd));
        chk("digit_valid", 32'(digit_valid), 32'(m_valid));
        chk("code_error", 32'(code_error), 32'(m_err));
        chk("sticky_error", 32'(sticky_error), 32'(m_sticky));
        chk("digits", 32'(digits), 32'(model_digits()));
        chk("digit_count", 32'(digit_count), 32'(m_count));
    endtask

    task automatic step(input bit r, input bit e, input bit z);
        reset = r; bit_en = e; z_in = z;
        @(posedge clock);
        model_edge(r, e, z);
        #1;
        compare_all();
    endtask

    task automatic frame(input logic [3:0] code);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, code[i]);
    endtask

    initial begin
        int pulses;
        logic [3:0] c;

        // Reset state
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("reset_digits", 32'(digits), 32'h0);
        chk("reset_valid", 32'(digit_valid), 32'h0);

        // BCD 0 -> code 0011
        frame(4'b0011);
        chk("tp1_valid", 32'(digit_valid), 32'h1);
        chk("tp1_code", 32'(e3_code), 32'h3);
        chk("tp1_count", 32'(digit_count), 32'h1);

        // Codes 4, 12, 14 back to back
        frame(4'd4); frame(4'd12); frame(4'd14);
        chk("tp2_digits", 32'(digits), 32'h019B);
        chk("tp2_err", 32'(code_error), 32'h1);
        chk("tp2_bcd", 32'(bcd_digit), 32'hB);

        // Code 0 then valid 5: sticky holds
        frame(4'd0);
        chk("tp3_bcd", 32'(bcd_digit), 32'hD);
        frame(4'd5);
        chk("tp3_err", 32'(code_error), 32'h0);
        chk("tp3_sticky", 32'(sticky_error), 32'h1);

        // Five digits, oldest dropped
        step(1'b0, 1'b0, 1'b0);
        for (int d = 1; d <= 5; d++) frame(4'(d + 3));
        chk("tp4_digits", 32'(digits), 32'h2345);
        chk("tp4_count", 32'(digit_count), 32'h5);

        // Stall between bit 1 and bit 2; exactly one pulse
        c = 4'd9;
        pulses = 0;
        step(1'b1, 1'b1, c[0]); step(1'b1, 1'b1, c[1]);
        for (int i = 0; i < 3; i++) begin step(1'b1, 1'b0, 1'($urandom)); pulses += digit_valid; end
        step(1'b1, 1'b1, c[2]); pulses += digit_valid;
        step(1'b1, 1'b1, c[3]); pulses += digit_valid;
        chk("tp5_code", 32'(e3_code), 32'h9);
        for (int i = 0; i < 3; i++) begin step(1'b1, 1'b0, 1'b1); pulses += digit_valid; end
        chk("tp5_pulses", 32'(pulses), 32'h1);

        // Stall on bit 3, then complete
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b1); step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("tp5b_code", 32'(e3_code), 32'h6);

        // Reset mid-frame, then a fresh frame
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("tp6_count", 32'(digit_count), 32'h0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin step(1'b1, 1'b1, (i < 2) ? 1'b1 : 1'b0); pulses += digit_valid; end
        chk("tp6_nopulse", 32'(pulses), 32'h0);
        step(1'b1, 1'b1, 1'b0);
        chk("tp6_code", 32'(e3_code), 32'h3);
        chk("tp6_valid", 32'(digit_valid), 32'h1);

        // Random stream, long enough to saturate the counter
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 1400; i++)
            step(1'b1, ($urandom_range(0, 7) != 0), 1'($urandom));
        chk("sat_count", 32'(digit_count), 32'hFF);

        // Random stream with occasional resets
        for (int i = 0; i < 1500; i++)
            step(($urandom_range(0, 60) != 0), ($urandom_range(0, 3) != 0), 1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
